jpeg_byte_stuffer: RTL and testbench

JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

---
 rtl/jpeg_byte_stuffer_pkg.sv | 16 +
 rtl/jpeg_byte_stuffer.sv | 121 ++++++++++++
 tb/tb_jpeg_byte_stuffer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_byte_stuffer_pkg.sv
// Shared definitions for the JPEG byte stuffer: FSM state encoding, default
// input word width and the byte values involved in stuffing.
package jpeg_byte_stuffer_pkg;

  localparam int DEFAULT_IN_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    STUFF = 2'd2
  } state_e;

  localparam logic [7:0] STUFF_TRIGGER = 8'hFF;
  localparam logic [7:0] STUFF_BYTE    = 8'h00;

endpackage

// File: rtl/jpeg_byte_stuffer.sv
// Serialises queue words MSB-first into a byte queue, inserting 0x00 after
// every 0xFF payload byte; one byte per cycle with same-cycle refill at word ends.
module jpeg_byte_stuffer
  import jpeg_byte_stuffer_pkg::*;
#(
  parameter int IN_WIDTH = DEFAULT_IN_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                IN_PopReq,
  input  logic [IN_WIDTH-1:0] IN_Data,
  input  logic                IN_Empty,
  output logic                OUT_PushReq,
  output logic [7:0]          OUT_Data,
  input  logic                OUT_Full,
  output logic [31:0]         BYTE_COUNT
);

  localparam int NB = IN_WIDTH / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NB - 1);

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [IN_WIDTH-1:0] word_q, word_d;
  logic [31:0]         count_q, count_d;

  logic [7:0] cur_byte;
  logic       is_last;

  // Byte k of the held word, k = 0 being the most significant byte.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cur_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (k_q == KW'(i)) cur_byte = word_q[IN_WIDTH-1-8*i -: 8];
    end
  end

  assign is_last = (k_q == LAST_K);

  // Output decode; a pop in EMIT/STUFF only happens in the cycle the word's
  // final byte leaves, which is what allows refill with no bubble.
  always_comb begin
    IN_PopReq   = 1'b0;
    OUT_PushReq = 1'b0;
    OUT_Data    = 8'h00;
    case (state_q)
      IDLE: IN_PopReq = !IN_Empty;
      EMIT: begin
        OUT_Data    = cur_byte;
        OUT_PushReq = !OUT_Full;
        IN_PopReq   = !OUT_Full && is_last && (cur_byte != STUFF_TRIGGER) && !IN_Empty;
      end
      STUFF: begin
        OUT_Data    = STUFF_BYTE;
        OUT_PushReq = !OUT_Full;
        IN_PopReq   = !OUT_Full && is_last && !IN_Empty;
      end
      default: ;
    endcase
    if (RST) begin
      IN_PopReq   = 1'b0;
      OUT_PushReq = 1'b0;
    end
  end

  // Next-state and datapath update. IN_PopReq is only high when the held word
  // is finished, so a pop always means "load new word, restart at k=0".
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    word_d  = word_q;
    count_d = OUT_PushReq ? count_q + 32'd1 : count_q;
    case (state_q)
      IDLE: begin
        if (IN_PopReq) begin
          word_d  = IN_Data;
          k_d     = '0;
          state_d = EMIT;
        end
      end
      EMIT, STUFF: begin
        if (OUT_PushReq) begin
          if (state_q == EMIT && cur_byte == STUFF_TRIGGER) begin
            state_d = STUFF;
          end else if (!is_last) begin
            k_d     = k_q + KW'(1);
            state_d = EMIT;
          end else if (IN_PopReq) begin
            word_d  = IN_Data;
            k_d     = '0;
            state_d = EMIT;
          end else begin
            k_d     = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign BYTE_COUNT = count_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Self-checking bench for jpeg_byte_stuffer: models both queues, predicts the
// stuffed byte stream from popped words and scores every push against it.
module tb_jpeg_byte_stuffer;
  import jpeg_byte_stuffer_pkg::*;

  localparam int W  = DEFAULT_IN_WIDTH;
  localparam int NB = W / 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         IN_PopReq;
  logic [W-1:0] IN_Data = '0;
  logic         IN_Empty = 1'b1;
  logic         OUT_PushReq;
  logic [7:0]   OUT_Data;
  logic         OUT_Full = 1'b0;
  logic [31:0]  BYTE_COUNT;

  jpeg_byte_stuffer #(.IN_WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_PopReq   (IN_PopReq),
    .IN_Data     (IN_Data),
    .IN_Empty    (IN_Empty),
    .OUT_PushReq (OUT_PushReq),
    .OUT_Data    (OUT_Data),
    .OUT_Full    (OUT_Full),
    .BYTE_COUNT  (BYTE_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] src_q[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   push_data[$];
  int           push_cycles[$];
  int           pop_cycles[$];
  logic [31:0]  exp_count = '0;
  int           cyc = 0;
  bit           rst_drv = 1'b1;
  bit           full_drv = 1'b0;
  bit           empty_force = 1'b0;
  bit           last_push, last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output for one word: bytes MSB first, each 0xFF followed by 0x00.
  task automatic append_word(input logic [W-1:0] w);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      b = w[W-1-8*i -: 8];
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic clear_log();
    push_data.delete();
    push_cycles.delete();
    pop_cycles.delete();
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, the posedge follows.
  task automatic tick();
    logic [7:0] exp_b;
    logic       have;
    @(negedge CLK);
    RST      = rst_drv;
    IN_Empty = empty_force || (src_q.size() == 0);
    IN_Data  = (src_q.size() != 0) ? src_q[0] : '0;
    OUT_Full = full_drv;
    #1;
    cyc++;
    last_push = OUT_PushReq && !OUT_Full;
    last_pop  = IN_PopReq && !IN_Empty;
    check("pop_when_empty", 32'(IN_PopReq && IN_Empty), 32'd0);
    check("push_when_full", 32'(OUT_PushReq && OUT_Full), 32'd0);
    check("byte_count", BYTE_COUNT, exp_count);
    if (RST) begin
      check("rst_pop", 32'(IN_PopReq), 32'd0);
      check("rst_push", 32'(OUT_PushReq), 32'd0);
      exp_q.delete();
      exp_count = '0;
    end else begin
      if (last_push) begin
        have  = (exp_q.size() != 0);
        exp_b = have ? exp_q.pop_front() : 8'h00;
        check("out_byte", {23'd0, 1'b1, OUT_Data}, {23'd0, have, exp_b});
        push_cycles.push_back(cyc);
        push_data.push_back(OUT_Data);
        exp_count++;
      end
      if (last_pop) begin
        append_word(src_q.pop_front());
        pop_cycles.push_back(cyc);
      end
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  task automatic run_until_push(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (last_push) break;
    end
    check(tag, 32'(last_push), 32'd1);
  endtask

  initial begin
    logic [W-1:0] w;
    int injected;

    // Reset with a word waiting: nothing may be popped or pushed.
    src_q.push_back(32'hDEADBEEF);
    tick();
    tick();
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    src_q.delete();
    rst_drv = 1'b0;
    tick();
    check("post_rst_count", BYTE_COUNT, 32'd0);

    // Two plain words stream out on 8 consecutive cycles.
    clear_log();
    src_q = '{32'h11223344, 32'h55667788};
    drain("r34_drain", 40);
    tick();
    check("r34_pushes", 32'(push_cycles.size()), 32'd8);
    check("r34_span", 32'(push_cycles[7] - push_cycles[0]), 32'd7);
    check("r34_latency", 32'(push_cycles[0] - pop_cycles[0]), 32'd1);
    check("r34_refill", 32'(pop_cycles[1]), 32'(push_cycles[3]));
    check("r34_count", BYTE_COUNT, 32'd8);

    // Stuffing: 12 FF 00 34 FF 00, refill pop lands on the final 00 push.
    clear_log();
    src_q = '{32'h12FF34FF, 32'hA1A2A3A4};
    drain("r35_drain", 40);
    tick();
    check("r35_pushes", 32'(push_cycles.size()), 32'd10);
    check("r35_stuff0", 32'(push_data[2]), 32'h00);
    check("r35_stuff1", 32'(push_data[5]), 32'h00);
    check("r35_refill", 32'(pop_cycles[1]), 32'(push_cycles[5]));
    check("r35_span", 32'(push_cycles[9] - push_cycles[0]), 32'd9);
    check("r35_count", BYTE_COUNT, 32'd18);

    // Downstream stall after the first byte holds BB and blocks pops.
    clear_log();
    src_q = '{32'hAABBCCDD, 32'h01020304};
    run_until_push("r36_first", 6);
    full_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r36_hold", 32'(OUT_Data), 32'hBB);
      check("r36_nopop", 32'(IN_PopReq), 32'd0);
    end
    full_drv = 1'b0;
    drain("r36_drain", 40);
    check("r36_pushes", 32'(push_data.size()), 32'd8);
    check("r36_last", 32'(push_data[3]), 32'hDD);

    // Upstream empty for 5 cycles between words.
    src_q.push_back(32'hC0C1C2C3);
    drain("r37_drain_a", 20);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r37_idle", 32'(dut.state_q), 32'(IDLE));
      check("r37_pop", 32'(IN_PopReq), 32'd0);
      check("r37_push", 32'(OUT_PushReq), 32'd0);
    end
    clear_log();
    src_q.push_back(32'hD0D1D2D3);
    drain("r37_drain_b", 20);
    check("r37_latency", 32'(push_cycles[0] - pop_cycles[0]), 32'd1);

    // Reset while the stuff byte is pending discards it.
    clear_log();
    src_q.push_back(32'hFF000000);
    run_until_push("r38_ff", 6);
    check("r38_ff_byte", 32'(OUT_Data), 32'hFF);
    rst_drv = 1'b1;
    tick();
    check("r38_in_stuff", 32'(dut.state_q), 32'(STUFF));
    rst_drv = 1'b0;
    clear_log();
    src_q.push_back(32'h01020304);
    tick();
    check("r38_count_zero", BYTE_COUNT, 32'd0);
    drain("r38_drain", 20);
    tick();
    check("r38_pushes", 32'(push_data.size()), 32'd4);
    check("r38_b0", 32'(push_data[0]), 32'h01);
    check("r38_b3", 32'(push_data[3]), 32'h04);
    check("r38_count", BYTE_COUNT, 32'd4);

    // Random words (FF-heavy) with random stalls on both sides.
    injected = 0;
    for (int c = 0; c < 4000 && (injected < 40 || src_q.size() != 0 || exp_q.size() != 0); c++) begin
      if (injected < 40 && src_q.size() < 3 && $urandom_range(0, 1) == 0) begin
        for (int i = 0; i < NB; i++)
          w[W-1-8*i -: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        src_q.push_back(w);
        injected++;
      end
      full_drv    = ($urandom_range(0, 3) == 0);
      empty_force = ($urandom_range(0, 4) == 0);
      tick();
    end
    full_drv    = 1'b0;
    empty_force = 1'b0;
    check("rand_injected", 32'(injected), 32'd40);
    drain("rand_drain", 100);
    tick();
    check("rand_count", BYTE_COUNT, exp_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
